// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external 32-bit ALU between two requesters.
// Operands are registered, executed for one cycle, and the result is held on a single response channel.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             rr_ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_ctrl;
  logic             op_id;
  logic             grant0;
  logic             grant1;
  logic             legal;

  // Grants are held low while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (rr_ptr) begin
        grant1 = req1_valid;
        grant0 = req0_valid & ~req1_valid;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
      end
    end
  end

  always_comb begin
    case (op_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_ctrl   = op_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      op_id       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a    <= grant1 ? req1_a  : req0_a;
            op_b    <= grant1 ? req1_b  : req0_b;
            op_ctrl <= grant1 ? req1_op : req0_op;
            op_id   <= grant1;
            rr_ptr  <= grant0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          if (legal) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_err    <= 1'b0;
          end else begin
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [31:0] resp_result;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  // Reference ALU; illegal codes return junk so the DUT must ignore them.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_ctrl == 4'b1111) ? 1'b1 : (alu_result == 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    #1;
    checks++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0 got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready1 got %b want 0", req1_ready); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if ({resp_id, resp_zero, resp_err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {resp_id, resp_zero, resp_err}); end
    checks++; if (resp_result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", resp_result); end
    checks++; if ({alu_a, alu_b, alu_ctrl} !== 68'h0) begin fails++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_a, alu_b, alu_ctrl); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    req0_a = 32'h10; req0_b = 32'h20; req0_op = 4'b0010; req0_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    checks++; if ({alu_a, alu_ctrl} !== {32'h10, 4'b0010}) begin fails++; $display("FAIL add_alu_drive got %h/%h want 10/2", alu_a, alu_ctrl); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL add_exec_valid got %b want 0", resp_valid); end
    tick();
    checks++; if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b1000) begin fails++; $display("FAIL add_flags got %b want 1000", {resp_valid, resp_id, resp_zero, resp_err}); end
    checks++; if (resp_result !== 32'h30) begin fails++; $display("FAIL add_result got %h want 00000030", resp_result); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL add_release got %b want 0", resp_valid); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    resp_ready = 1'b1;
    req0_a = 32'h30; req0_b = 32'h10; req0_op = 4'b0110; req0_valid = 1'b1;
    req1_a = 32'hF0F0F0F0; req1_b = 32'h0F0F0F0F; req1_op = 4'b0000; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL simul_first_grant got %b want 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++; if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b1000) begin fails++; $display("FAIL simul_r0_flags got %b want 1000", {resp_valid, resp_id, resp_zero, resp_err}); end
    checks++; if (resp_result !== 32'h20) begin fails++; $display("FAIL simul_r0_result got %h want 00000020", resp_result); end
    checks++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL simul_no_accept_in_resp got %b want 0", req1_ready); end
    tick();
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL simul_second_grant got %b want 01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++; if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b1110) begin fails++; $display("FAIL simul_r1_flags got %b want 1110", {resp_valid, resp_id, resp_zero, resp_err}); end
    checks++; if (resp_result !== 32'h0) begin fails++; $display("FAIL simul_r1_result got %h want 00000000", resp_result); end
    tick();
  endtask

  task automatic test_zero_fairness();
    logic exp_id;
    resp_ready = 1'b1;
    req1_a = 32'h12345678; req1_b = 32'h12345678; req1_op = 4'b0110; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL zero_grant got %b want 01", {req0_ready, req1_ready}); end
    tick();
    req0_a = 32'hF0F0F0F0; req0_b = 32'h0F0F0F0F; req0_op = 4'b0001; req0_valid = 1'b1;
    req1_a = 32'hF0F0F0F0; req1_b = 32'h0F0F0F0F; req1_op = 4'b0001;
    tick();
    checks++; if ({resp_valid, resp_id, resp_zero} !== 3'b111) begin fails++; $display("FAIL zero_flag got %b want 111", {resp_valid, resp_id, resp_zero}); end
    checks++; if (resp_result !== 32'h0) begin fails++; $display("FAIL zero_result got %h want 00000000", resp_result); end
    exp_id = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin fails++; $display("FAIL fair_grant_%0d got %b want id %0d", i, {req0_ready, req1_ready}, exp_id); end
      tick();
      tick();
      checks++; if ({resp_valid, resp_id, resp_zero} !== {1'b1, exp_id, 1'b0}) begin fails++; $display("FAIL fair_resp_%0d got %b want 1%b0", i, {resp_valid, resp_id, resp_zero}, exp_id); end
      checks++; if (resp_result !== 32'hFFFFFFFF) begin fails++; $display("FAIL fair_result_%0d got %h want ffffffff", i, resp_result); end
      exp_id = ~exp_id;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    resp_ready = 1'b0;
    req0_a = 32'h5; req0_b = 32'h7; req0_op = 4'b0010; req0_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({resp_valid, resp_id, resp_zero, resp_err, req0_ready} !== 5'b10000) begin fails++; $display("FAIL bp_hold_%0d got %b want 10000", i, {resp_valid, resp_id, resp_zero, resp_err, req0_ready}); end
      checks++; if (resp_result !== 32'hC) begin fails++; $display("FAIL bp_result_%0d got %h want 0000000c", i, resp_result); end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_on_rise got %b want 0", req0_ready); end
    tick();
    checks++; if ({resp_valid, req0_ready} !== 2'b01) begin fails++; $display("FAIL bp_accept_after got %b want 01", {resp_valid, req0_ready}); end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    resp_ready = 1'b1;
    req0_a = 32'h1; req0_b = 32'h1; req0_op = 4'b1111; req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL illegal_grant got %b want 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++; if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b1001) begin fails++; $display("FAIL illegal_flags got %b want 1001", {resp_valid, resp_id, resp_zero, resp_err}); end
    checks++; if (resp_result !== 32'h0) begin fails++; $display("FAIL illegal_result got %h want 00000000", resp_result); end
    tick();
  endtask

  task automatic test_reset_exec();
    logic saw_valid;
    resp_ready = 1'b1;
    req0_a = 32'hAA; req0_b = 32'h55; req0_op = 4'b0001; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({resp_valid, resp_id, resp_zero, resp_err} !== 4'b0000) begin fails++; $display("FAIL rexec_flags got %b want 0000", {resp_valid, resp_id, resp_zero, resp_err}); end
    checks++; if ({resp_result, alu_a, alu_b, alu_ctrl} !== 100'h0) begin fails++; $display("FAIL rexec_data got %h/%h/%h/%h want 0", resp_result, alu_a, alu_b, alu_ctrl); end
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_valid = saw_valid | resp_valid;
    end
    checks++; if (saw_valid !== 1'b0) begin fails++; $display("FAIL rexec_no_pulse got %b want 0", saw_valid); end
    req0_op = 4'b0010; req1_op = 4'b0010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL rexec_grant got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_simultaneous();
    test_zero_fairness();
    test_backpressure();
    test_illegal();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
